req_pulse_monitor: RTL and testbench

//  Multi-channel synthesizable monitor for request-pulse shape (max high run, min low gap).

---
 rtl/req_pulse_monitor.sv | 192 +++++++++++++++++++
 tb/tb_req_pulse_monitor.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_pulse_monitor.sv
// -----------------------------------------------------------------------------
// req_pulse_monitor
//
// Purpose:
//   Multi-channel monitor for the shape of request pulses. Each channel checks
//   two rules on its req line, sampled on every rising clk edge:
//     WIDTH : a pulse may stay high for at most MAX_HIGH consecutive cycles.
//             One violation is counted per pulse, on the first extra cycle.
//     GAP   : consecutive pulses must be separated by at least MIN_LOW low
//             cycles. The first pulse after reset, clr or enable rising is
//             exempt because no previous pulse is known.
//   Every violation produces a one-cycle err_pulse strobe, sets a sticky
//   flag and bumps a saturating per-channel counter. All reporting is by
//   registered outputs; nothing is printed.
//
// Parameters:
//   NUM_CH   : number of independent req channels (>= 1)
//   MAX_HIGH : max consecutive high cycles per pulse (>= 1)
//   MIN_LOW  : min consecutive low cycles between pulses (>= 1)
//   CNT_W    : width of each saturating violation counter (>= 1)
//
// Ports:
//   clk        : clock, all sampling on posedge
//   rst_n      : asynchronous reset, active low
//   enable     : monitoring enable; low parks every channel in idle
//                (flags and counters hold, err_pulse is 0)
//   clr        : synchronous clear of channel state, counters and flags;
//                takes priority over enable and over same-cycle violations
//   req        : monitored request lines, bit i = channel i
//   err_pulse  : one-cycle registered strobe per violation
//   err_sticky : sticky per-channel violation flag
//   err_cnt    : per-channel violation count, channel i at [i*CNT_W +: CNT_W]
//   any_err    : OR of err_sticky
//
// Build option:
//   REQ_PULSE_MONITOR_SVA_EN : when defined, adds per-channel concurrent
//   assertions mirroring the WIDTH and GAP rules. Counter and flag behaviour
//   is identical with or without it.
// -----------------------------------------------------------------------------
module req_pulse_monitor #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned MAX_HIGH = 1,
    parameter int unsigned MIN_LOW  = 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    clr,
    input  logic [NUM_CH-1:0]       req,
    output logic [NUM_CH-1:0]       err_pulse,
    output logic [NUM_CH-1:0]       err_sticky,
    output logic [NUM_CH*CNT_W-1:0] err_cnt,
    output logic                    any_err
);

    // Counters only need to reach their saturation value.
    localparam int unsigned HI_W = (MAX_HIGH > 1) ? $clog2(MAX_HIGH + 1) : 1;
    localparam int unsigned LO_W = (MIN_LOW > 1) ? $clog2(MIN_LOW + 1) : 1;

    localparam logic [HI_W-1:0]  HI_MAX  = HI_W'(MAX_HIGH);
    localparam logic [LO_W-1:0]  LO_MIN  = LO_W'(MIN_LOW);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // StIdle : no pulse seen since reset/clr/enable rising
    // StHigh : inside a pulse, still within MAX_HIGH
    // StOver : pulse already flagged as too wide, waiting for it to end
    // StLow  : between pulses, counting the low gap
    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StOver,
        StLow
    } state_e;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

        state_e           state_q;
        logic [HI_W-1:0]  hi_cnt_q;
        logic [LO_W-1:0]  lo_cnt_q;
        logic             pulse_q;
        logic             sticky_q;
        logic [CNT_W-1:0] cnt_q;

        logic             width_viol;
        logic             gap_viol;
        logic             viol;

        // The (MAX_HIGH+1)-th high sample of a pulse is the width violation.
        assign width_viol = (state_q == StHigh) && req[i] && (hi_cnt_q == HI_MAX);
        // A rise out of StLow before the gap reached MIN_LOW. StIdle never
        // reaches here, which exempts the first pulse.
        assign gap_viol   = (state_q == StLow) && req[i] && (lo_cnt_q < LO_MIN);
        assign viol       = width_viol || gap_viol;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= StIdle;
                hi_cnt_q <= '0;
                lo_cnt_q <= '0;
                pulse_q  <= 1'b0;
                sticky_q <= 1'b0;
                cnt_q    <= '0;
            end else if (clr) begin
                // Any violation sampled in this cycle is dropped.
                state_q  <= StIdle;
                hi_cnt_q <= '0;
                lo_cnt_q <= '0;
                pulse_q  <= 1'b0;
                sticky_q <= 1'b0;
                cnt_q    <= '0;
            end else if (!enable) begin
                // Park the channel; flags and counters keep their values.
                state_q  <= StIdle;
                hi_cnt_q <= '0;
                lo_cnt_q <= '0;
                pulse_q  <= 1'b0;
            end else begin
                pulse_q <= viol;
                if (viol) begin
                    sticky_q <= 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                unique case (state_q)
                    StIdle: begin
                        if (req[i]) begin
                            state_q  <= StHigh;
                            hi_cnt_q <= HI_W'(1);
                        end
                    end
                    StHigh: begin
                        if (req[i]) begin
                            if (hi_cnt_q == HI_MAX) begin
                                state_q <= StOver;
                            end else begin
                                hi_cnt_q <= hi_cnt_q + HI_W'(1);
                            end
                        end else begin
                            state_q  <= StLow;
                            lo_cnt_q <= LO_W'(1);
                        end
                    end
                    StOver: begin
                        if (!req[i]) begin
                            state_q  <= StLow;
                            lo_cnt_q <= LO_W'(1);
                        end
                    end
                    StLow: begin
                        if (req[i]) begin
                            // Gap violation or not, a new pulse starts here.
                            state_q  <= StHigh;
                            hi_cnt_q <= HI_W'(1);
                        end else if (lo_cnt_q != LO_MIN) begin
                            lo_cnt_q <= lo_cnt_q + LO_W'(1);
                        end
                    end
                    default: begin
                        state_q  <= StIdle;
                        hi_cnt_q <= '0;
                        lo_cnt_q <= '0;
                    end
                endcase
            end
        end

        assign err_pulse[i]                 = pulse_q;
        assign err_sticky[i]                = sticky_q;
        assign err_cnt[i*CNT_W +: CNT_W]    = cnt_q;

`ifdef REQ_PULSE_MONITOR_SVA_EN
        // A pulse that has been high MAX_HIGH cycles must drop next cycle.
        a_width : assert property (@(posedge clk) disable iff (!rst_n || clr || !enable)
            ($rose(req[i]) ##0 req[i] [*MAX_HIGH]) |=> !req[i])
            else $error("ch %0d", i);

        // Once a pulse ends, req must stay low for MIN_LOW cycles.
        a_gap : assert property (@(posedge clk) disable iff (!rst_n || clr || !enable)
            $fell(req[i]) |-> !req[i] [*MIN_LOW])
            else $error("ch %0d", i);
`else
        // Assertions not compiled in this build.
`endif

    end : g_ch

    assign any_err = |err_sticky;

endmodule

// File: tb/tb_req_pulse_monitor.sv
// -----------------------------------------------------------------------------
// tb_req_pulse_monitor
//
// Drives three monitor instances with shared inputs:
//   dut 0 : NUM_CH=4 MAX_HIGH=1 MIN_LOW=1 CNT_W=8 (defaults)
//   dut 1 : NUM_CH=4 MAX_HIGH=3 MIN_LOW=2 CNT_W=2
//   dut 2 : NUM_CH=4 MAX_HIGH=1 MIN_LOW=3 CNT_W=4
// The reference model tracks high/low run lengths per channel and derives
// violations from them; a compare process checks every output each cycle.
// -----------------------------------------------------------------------------
module tb_req_pulse_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        clr;
    logic [3:0]  req;

    logic [3:0]  p0, s0, p1, s1, p2, s2;
    logic [31:0] c0;
    logic [7:0]  c1;
    logic [15:0] c2;
    logic        a0, a1, a2;

    always #5 clk = ~clk;

    req_pulse_monitor #(.NUM_CH(4), .MAX_HIGH(1), .MIN_LOW(1), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .req(req),
        .err_pulse(p0), .err_sticky(s0), .err_cnt(c0), .any_err(a0)
    );
    req_pulse_monitor #(.NUM_CH(4), .MAX_HIGH(3), .MIN_LOW(2), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .req(req),
        .err_pulse(p1), .err_sticky(s1), .err_cnt(c1), .any_err(a1)
    );
    req_pulse_monitor #(.NUM_CH(4), .MAX_HIGH(1), .MIN_LOW(3), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .req(req),
        .err_pulse(p2), .err_sticky(s2), .err_cnt(c2), .any_err(a2)
    );

    // DUT outputs gathered per instance for the compare loop.
    logic [3:0] got_p[3];
    logic [3:0] got_s[3];
    logic       got_a[3];
    int         got_c[3][4];

    always_comb begin
        got_p[0] = p0; got_p[1] = p1; got_p[2] = p2;
        got_s[0] = s0; got_s[1] = s1; got_s[2] = s2;
        got_a[0] = a0; got_a[1] = a1; got_a[2] = a2;
        for (int c = 0; c < 4; c++) begin
            got_c[0][c] = int'(c0[c*8 +: 8]);
            got_c[1][c] = int'(c1[c*2 +: 2]);
            got_c[2][c] = int'(c2[c*4 +: 4]);
        end
    end

    function automatic int cfg_maxh(input int d);
        return (d == 1) ? 3 : 1;
    endfunction
    function automatic int cfg_minl(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 3);
    endfunction
    function automatic int cfg_cw(input int d);
        return (d == 0) ? 8 : ((d == 1) ? 2 : 4);
    endfunction

    // Reference model state.
    int         hr[3][4];    // length of the current high run
    int         lr[3][4];    // low samples since the last high sample
    bit         inp[3][4];   // last monitored sample was high
    bit         seen[3][4];  // a pulse was seen since reset/clr/enable rising
    logic [3:0] exp_p[3];
    logic [3:0] exp_s[3];
    int         exp_c[3][4];

    int  n_vec = 0;
    int  n_err = 0;
    bit  chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            exp_p[d] = '0;
            exp_s[d] = '0;
            for (int c = 0; c < 4; c++) begin
                hr[d][c] = 0; lr[d][c] = 0; inp[d][c] = 0; seen[d][c] = 0;
                exp_c[d][c] = 0;
            end
        end
    endtask

    // One sampling edge of the specification's rules.
    task automatic model_step();
        bit v;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < 4; c++) begin
                v = 0;
                if (clr) begin
                    hr[d][c] = 0; lr[d][c] = 0; inp[d][c] = 0; seen[d][c] = 0;
                    exp_p[d][c] = 0; exp_s[d][c] = 0; exp_c[d][c] = 0;
                    continue;
                end
                if (!enable) begin
                    inp[d][c] = 0; seen[d][c] = 0; exp_p[d][c] = 0;
                    continue;
                end
                if (req[c]) begin
                    if (!inp[d][c]) begin
                        if (seen[d][c] && lr[d][c] < cfg_minl(d)) v = 1;
                        hr[d][c] = 1; inp[d][c] = 1; seen[d][c] = 1;
                    end else begin
                        if (hr[d][c] < 1000) hr[d][c]++;
                        if (hr[d][c] == cfg_maxh(d) + 1) v = 1;
                    end
                end else begin
                    if (inp[d][c]) lr[d][c] = 1;
                    else if (lr[d][c] < 1000) lr[d][c]++;
                    inp[d][c] = 0;
                end
                exp_p[d][c] = v;
                if (v) begin
                    exp_s[d][c] = 1;
                    if (exp_c[d][c] < (1 << cfg_cw(d)) - 1) exp_c[d][c]++;
                end
            end
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                check($sformatf("dut%0d err_pulse", d), got_p[d], exp_p[d]);
                check($sformatf("dut%0d err_sticky", d), got_s[d], exp_s[d]);
                check($sformatf("dut%0d any_err", d), got_a[d], |exp_s[d]);
                for (int c = 0; c < 4; c++)
                    check($sformatf("dut%0d err_cnt[%0d]", d, c), got_c[d][c], exp_c[d][c]);
            end
        end
    end

    // One clock cycle: inputs applied at negedge, model stepped at posedge.
    task automatic cyc(input logic en, input logic cl, input logic [3:0] r);
        enable = en; clr = cl; req = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    int nstb;
    logic [3:0] rv;

    initial begin
        rst_n = 1'b0; enable = 1'b0; clr = 1'b0; req = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        // Reset state.
        check("reset any_err dut0", a0, 0);
        check("reset err_cnt dut0", int'(c0), 0);
        check("reset err_sticky dut1", s1, 0);

        // 1: 1-high / 3-low pulses are legal for every config.
        cyc(1, 0, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 0, 4'b0001);
            for (int j = 0; j < 3; j++) cyc(1, 0, 4'b0000);
        end
        check("t1 cnt0 dut0", got_c[0][0], 0);
        check("t1 any_err dut0", a0, 0);
        check("t1 any_err dut2", a2, 0);

        // 2: 3-cycle pulse on ch1 -> one width strobe on the 2nd high cycle (dut0).
        cyc(1, 1, 4'b0000);
        cyc(1, 0, 4'b0010);
        check("t2 strobe early", p0[1], 0);
        cyc(1, 0, 4'b0010);
        check("t2 strobe 2nd high", p0[1], 1);
        check("t2 model strobe", exp_p[0][1], 1);
        cyc(1, 0, 4'b0010);
        check("t2 strobe once", p0[1], 0);
        check("t2 cnt1 dut0", got_c[0][1], 1);
        check("t2 sticky1 dut0", s0[1], 1);
        check("t2 cnt1 dut1 (MAX_HIGH=3)", got_c[1][1], 0);
        cyc(1, 0, 4'b0000);

        // 3: 1,0,1 on ch2 -> gap violation on the 2nd rise when MIN_LOW>1.
        cyc(1, 1, 4'b0000);
        cyc(1, 0, 4'b0100);
        check("t3 first pulse clean", p1[2], 0);
        cyc(1, 0, 4'b0000);
        cyc(1, 0, 4'b0100);
        check("t3 gap strobe dut1", p1[2], 1);
        cyc(1, 0, 4'b0000);
        cyc(1, 0, 4'b0000);
        check("t3 cnt2 dut1", got_c[1][2], 1);
        check("t3 cnt2 dut2 single violation", got_c[2][2], 1);
        check("t3 model cnt2 dut2", exp_c[2][2], 1);
        check("t3 cnt2 dut0", got_c[0][2], 0);

        // 4: five over-long pulses on ch3; dut1 counter saturates at 3.
        cyc(1, 1, 4'b0000);
        nstb = 0;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++) begin
                cyc(1, 0, 4'b1000);
                if (p1[3]) nstb++;
            end
            for (int j = 0; j < 2; j++) begin
                cyc(1, 0, 4'b0000);
                if (p1[3]) nstb++;
            end
        end
        check("t4 strobes dut1", nstb, 5);
        check("t4 cnt3 dut1 saturated", got_c[1][3], 3);
        check("t4 cnt3 dut0", got_c[0][3], 5);
        check("t4 model cnt3 dut2", exp_c[2][3], 9);

        // 5: simultaneous violations, then a violation dropped by clr.
        cyc(1, 1, 4'b0000);
        cyc(1, 0, 4'b0101);
        cyc(1, 0, 4'b0101);
        check("t5 dual strobe dut0", p0, 4'b0101);
        cyc(1, 0, 4'b0000);
        cyc(1, 0, 4'b0101);
        cyc(1, 1, 4'b0101);
        check("t5 clr strobe dut0", p0, 0);
        check("t5 clr cnt dut0", int'(c0), 0);
        check("t5 clr any_err dut0", a0, 0);
        cyc(1, 0, 4'b0000);

        // 6: reset mid-pulse, then enable low during an over-long pulse.
        cyc(1, 0, 4'b0010);
        cyc(1, 0, 4'b0010);
        check("t6 pre-reset any_err", a0, 1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("t6 async reset any_err", a0, 0);
        check("t6 async reset pulse", p0, 0);
        check("t6 async reset cnt", int'(c0), 0);
        cyc(1, 0, 4'b0010);
        #2 rst_n = 1'b1;
        cyc(1, 0, 4'b0010);
        check("t6 post-reset first pulse", p0[1], 0);
        cyc(1, 0, 4'b0010);
        cyc(1, 0, 4'b0000);
        check("t6 post-reset width cnt", got_c[0][1], 1);
        for (int j = 0; j < 4; j++) cyc(0, 0, 4'b1000);
        check("t6 disabled pulse", p0, 0);
        check("t6 disabled cnt3", got_c[0][3], 0);
        check("t6 disabled cnt1 holds", got_c[0][1], 1);
        cyc(1, 0, 4'b1000);
        cyc(1, 0, 4'b0000);
        check("t6 first pulse after enable dut0", got_c[0][3], 0);
        check("t6 first pulse after enable dut2", got_c[2][3], 0);

        // Randomized phase.
        rv = '0;
        for (int k = 0; k < 4000; k++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 99) < 35) rv[b] = ~rv[b];
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                model_reset();
                #2 rst_n = 1'b1;
            end
            cyc(($urandom_range(0, 39) != 0), ($urandom_range(0, 149) == 0), rv);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
